beep_tone_gen: RTL and testbench



---
 rtl/beep_tone_gen.sv | 160 ++++++++++++++++
 tb/tb_beep_tone_gen.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/beep_tone_gen.sv
// Multi-key debounced buzzer: the lowest pressed key selects a square-wave pitch.
// Define BEEP_LATCH_EN for latch mode, where a press toggles/switches the tone instead of holding it.
module beep_tone_gen #(
  parameter int unsigned KEY_NUM    = 4,
  parameter int unsigned DEB_CYCLES = 1_000_000,
  parameter int unsigned BASE_HALF  = 95_556,
  parameter int unsigned STEP_HALF  = 10_000,
  localparam int unsigned IdxW      = (KEY_NUM > 1) ? $clog2(KEY_NUM) : 1
) (
  input  logic               sys_clk,
  input  logic               rst_n,
  input  logic [KEY_NUM-1:0] key,
  output logic               beep,
  output logic [KEY_NUM-1:0] led,
  output logic               tone_vld,
  output logic [IdxW-1:0]    tone_idx
);

  localparam int unsigned DebW    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned MaxHalf = BASE_HALF + (KEY_NUM - 1) * STEP_HALF;
  localparam int unsigned CntW    = $clog2(MaxHalf + 1);

  typedef logic [KEY_NUM-1:0][CntW-1:0] half_tab_t;

  // Terminal count (HALF(i)-1) for each tone.
  function automatic half_tab_t gen_half_tab();
    half_tab_t tab;
    for (int unsigned i = 0; i < KEY_NUM; i++) begin
      tab[i] = CntW'(BASE_HALF + i * STEP_HALF - 1);
    end
    return tab;
  endfunction

  localparam half_tab_t HalfM1 = gen_half_tab();

  typedef enum logic {StIdle, StPlay} state_e;

  logic [KEY_NUM-1:0] r_sync1, r_sync2, r_stable, r_led;
  logic [DebW-1:0]    r_deb_cnt [KEY_NUM];
  state_e             r_state;
  logic [CntW-1:0]    r_cnt;
  logic               r_beep;
  logic [IdxW-1:0]    r_idx;
  logic               w_wrap;

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      r_sync1  <= '1;
      r_sync2  <= '1;
      r_stable <= '1;
      r_led    <= '0;
      for (int i = 0; i < int'(KEY_NUM); i++) r_deb_cnt[i] <= '0;
    end else begin
      r_sync1 <= key;
      r_sync2 <= r_sync1;
      r_led   <= ~r_stable;
      for (int i = 0; i < int'(KEY_NUM); i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == DebW'(DEB_CYCLES - 1)) begin
          r_stable[i]  <= r_sync2[i];
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_wrap = (r_cnt == HalfM1[r_idx]);

`ifdef BEEP_LATCH_EN
  logic [KEY_NUM-1:0] r_prev, w_ev;
  logic [IdxW-1:0]    w_ev_idx;
  logic               w_ev_any;

  always_ff @(posedge sys_clk) begin
    if (!rst_n) r_prev <= '1;
    else        r_prev <= r_stable;
  end

  // Press event = debounced 1->0 transition; lowest index wins.
  always_comb begin
    w_ev     = r_prev & ~r_stable;
    w_ev_any = |w_ev;
    w_ev_idx = '0;
    for (int i = int'(KEY_NUM) - 1; i >= 0; i--) begin
      if (w_ev[i]) w_ev_idx = IdxW'(i);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_beep  <= 1'b0;
      r_idx   <= '0;
    end else if (w_ev_any) begin
      r_cnt  <= '0;
      r_beep <= 1'b0;
      if (r_state == StPlay && w_ev_idx == r_idx) begin
        r_state <= StIdle;
        r_idx   <= '0;
      end else begin
        r_state <= StPlay;
        r_idx   <= w_ev_idx;
      end
    end else if (r_state == StPlay) begin
      if (w_wrap) begin
        r_cnt  <= '0;
        r_beep <= ~r_beep;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
`else
  logic [IdxW-1:0] w_sel;
  logic            w_any;

  always_comb begin
    w_any = ~&r_stable;
    w_sel = '0;
    for (int i = int'(KEY_NUM) - 1; i >= 0; i--) begin
      if (!r_stable[i]) w_sel = IdxW'(i);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_beep  <= 1'b0;
      r_idx   <= '0;
    end else if (!w_any) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_beep  <= 1'b0;
      r_idx   <= '0;
    end else if (r_state == StIdle || w_sel != r_idx) begin
      // New or changed pitch restarts from a fresh low half-period.
      r_state <= StPlay;
      r_cnt   <= '0;
      r_beep  <= 1'b0;
      r_idx   <= w_sel;
    end else if (w_wrap) begin
      r_cnt  <= '0;
      r_beep <= ~r_beep;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`endif

  assign beep     = r_beep;
  assign led      = r_led;
  assign tone_vld = (r_state == StPlay);
  assign tone_idx = r_idx;

endmodule

// File: tb/tb_beep_tone_gen.sv
// Bench for beep_tone_gen: directed scenarios plus random key patterns against a window-based model.
module tb_beep_tone_gen;
  localparam int Deb  = 4;
  localparam int Base = 10;
  localparam int Step = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key;
  logic       beep, tone_vld;
  logic [3:0] led;
  logic [1:0] tone_idx;
  int         total = 0;
  int         bad = 0;

  beep_tone_gen #(.KEY_NUM(4), .DEB_CYCLES(Deb), .BASE_HALF(Base), .STEP_HALF(Step)) dut (
    .sys_clk(clk), .rst_n(rst_n), .key(key), .beep(beep), .led(led),
    .tone_vld(tone_vld), .tone_idx(tone_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] stable;
    logic [3:0] prev;
    logic       vld;
    logic [1:0] idx;
    int         start;
    int         n;
    logic [3:0] led;
    logic       beep;
  } model_t;

  model_t     m;
  logic [3:0] hist[$];

  // Key flips once its 2-cycle-delayed raw value has disagreed for Deb edges in a row.
  function automatic model_t step(model_t c, logic [3:0] k, logic rn);
    model_t     x = c;
    logic [3:0] ev;
    logic [1:0] sel;
    if (!rn) begin
      x = '0;
      x.stable = 4'hF;
      x.prev   = 4'hF;
      return x;
    end
    x.n   = c.n + 1;
    x.led = ~c.stable;
`ifdef BEEP_LATCH_EN
    ev = c.prev & ~c.stable;
    if (ev != 0) begin
      sel = 0;
      for (int i = 3; i >= 0; i--) if (ev[i]) sel = 2'(i);
      if (c.vld && sel == c.idx) begin
        x.vld = 0;
        x.idx = 0;
      end else begin
        x.vld = 1;
        x.idx = sel;
        x.start = x.n;
      end
    end
`else
    ev = 0;
    if (c.stable == 4'hF) begin
      x.vld = 0;
      x.idx = 0;
    end else begin
      sel = 0;
      for (int i = 3; i >= 0; i--) if (!c.stable[i]) sel = 2'(i);
      if (!c.vld || sel != c.idx) begin
        x.start = x.n;
        x.idx   = sel;
      end
      x.vld = 1;
    end
`endif
    x.beep = x.vld ? (((x.n - x.start) / (Base + Step * int'(x.idx))) % 2 == 1) : 1'b0;
    x.prev = c.stable;
    for (int i = 0; i < 4; i++) begin
      logic flip = 1'b1;
      for (int j = 0; j < Deb; j++) begin
        int   h = hist.size() - 2 - j;
        logic v = (h >= 0) ? hist[h][i] : 1'b1;
        if (v == c.stable[i]) flip = 1'b0;
      end
      if (flip) x.stable[i] = ~c.stable[i];
    end
    return x;
  endfunction

  always @(posedge clk) begin
    m <= step(m, key, rst_n);
    if (!rst_n) hist.delete();
    else hist.push_back(key);
  end

  task automatic test_reset();
    rst_n = 1'b0;
    key   = 4'hF;
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({beep, led, tone_vld, tone_idx} !== 8'h00) begin
        bad++;
        $display("FAIL reset: got %b expected 00000000", {beep, led, tone_vld, tone_idx});
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_key();
    key = 4'b1101;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      total++;
      if ({beep, led, tone_vld, tone_idx} !== {m.beep, m.led, m.vld, m.idx}) begin
        bad++;
        $display("FAIL single_model c=%0d: got %b expected %b", c,
                 {beep, led, tone_vld, tone_idx}, {m.beep, m.led, m.vld, m.idx});
      end
      if (c == 6 || c == 7) begin
        total++;
        if ({led, tone_vld, tone_idx} !== ((c == 7) ? 7'b0010_1_01 : 7'b0000_0_00)) begin
          bad++;
          $display("FAIL single_latency c=%0d: got %b", c, {led, tone_vld, tone_idx});
        end
      end
      if (c == 21 || c == 22 || c == 36 || c == 37) begin
        total++;
        if (beep !== (c == 22 || c == 36)) begin
          bad++;
          $display("FAIL single_beep c=%0d: got %b expected %b", c, beep, (c == 22 || c == 36));
        end
      end
    end
    key = 4'hF;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_glitch();
    rst_n = 1'b0;
    key   = 4'hF;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    key = 4'b1110;
    repeat (3) @(negedge clk);
    key = 4'hF;
    repeat (12) begin
      @(negedge clk);
      total++;
      if ({beep, led, tone_vld} !== 6'b0) begin
        bad++;
        $display("FAIL glitch: got %b expected 000000", {beep, led, tone_vld});
      end
    end
  endtask

  task automatic test_handover();
    key = 4'b1010;
    for (int c = 1; c <= 70; c++) begin
      if (c == 31) key = 4'b1011;
      @(negedge clk);
      total++;
      if ({beep, led, tone_vld, tone_idx} !== {m.beep, m.led, m.vld, m.idx}) begin
        bad++;
        $display("FAIL handover_model c=%0d: got %b expected %b", c,
                 {beep, led, tone_vld, tone_idx}, {m.beep, m.led, m.vld, m.idx});
      end
`ifndef BEEP_LATCH_EN
      // Release lands on edge 30+7; the new half is 20.
      if (c == 17 || c == 37 || c == 56 || c == 57) begin
        total++;
        if ({beep, tone_vld, tone_idx} !== {(c == 17 || c == 57), 1'b1, (c >= 37) ? 2'd2 : 2'd0}) begin
          bad++;
          $display("FAIL handover_tone c=%0d: got beep=%b vld=%b idx=%0d", c, beep, tone_vld,
                   tone_idx);
        end
      end
`endif
    end
    key = 4'hF;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid_tone();
    key = 4'b0111;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({beep, tone_vld, tone_idx} !== 4'b0) begin
      bad++;
      $display("FAIL reset_mid_tone: got %b expected 0000", {beep, tone_vld, tone_idx});
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      total++;
      if ({tone_vld, tone_idx} !== ((c == 7) ? 3'b1_11 : 3'b0)) begin
        bad++;
        $display("FAIL reset_redebounce c=%0d: got %b", c, {tone_vld, tone_idx});
      end
    end
    key = 4'hF;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_random();
    for (int s = 0; s < 60; s++) begin
      key = 4'($urandom);
      repeat ($urandom_range(1, 40)) begin
        @(negedge clk);
        total++;
        if ({beep, led, tone_vld, tone_idx} !== {m.beep, m.led, m.vld, m.idx}) begin
          bad++;
          $display("FAIL random s=%0d: got %b expected %b", s,
                   {beep, led, tone_vld, tone_idx}, {m.beep, m.led, m.vld, m.idx});
        end
      end
    end
  endtask

`ifdef BEEP_LATCH_EN
  task automatic test_latch();
    rst_n = 1'b0;
    key   = 4'hF;
    @(negedge clk);
    rst_n = 1'b1;
    for (int p = 0; p < 4; p++) begin
      key = (p % 2 == 0) ? 4'b1011 : 4'hF;
      repeat (12) begin
        @(negedge clk);
        total++;
        if ({beep, led, tone_vld, tone_idx} !== {m.beep, m.led, m.vld, m.idx}) begin
          bad++;
          $display("FAIL latch_model p=%0d: got %b expected %b", p,
                   {beep, led, tone_vld, tone_idx}, {m.beep, m.led, m.vld, m.idx});
        end
      end
      if (p == 1 || p == 3) begin
        total++;
        if ({tone_vld, tone_idx} !== ((p == 1) ? 3'b1_10 : 3'b0_00) || (p == 3 && beep !== 1'b0)) begin
          bad++;
          $display("FAIL latch_state p=%0d: got vld=%b idx=%0d beep=%b", p, tone_vld, tone_idx,
                   beep);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_key();
    test_glitch();
    test_handover();
    test_reset_mid_tone();
    test_random();
`ifdef BEEP_LATCH_EN
    test_latch();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
